// File: rtl/approx_mul_8x8_seq_ctrl.sv
// Sequencing controller for the 8x8 HA-array approximate multiplier: latches operands,
// walks the compressor's partial-product rows and accumulates them into a 16-bit product.
module approx_mul_8x8_seq_ctrl #(
  parameter bit SKIP_ZERO_ROWS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [7:0]  op_x,
  output logic [7:0]  op_y,
  input  logic [6:0]  row_b_0,
  input  logic [6:0]  row_b_1,
  input  logic [6:0]  row_b_2,
  input  logic [6:0]  row_b_3,
  input  logic [8:0]  row_t_0,
  input  logic [8:0]  row_t_1,
  input  logic [8:0]  row_t_2,
  input  logic [8:0]  row_t_3,
  output logic [1:0]  row_sel,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_op_x;
  logic [7:0]  r_op_y;
  logic [15:0] r_acc;
  logic [3:0]  r_mask;
  logic [1:0]  r_row_sel;

  logic [3:0]  w_mask_in;
  logic [3:0]  w_mask_rem;
  logic [8:0]  w_row_t;
  logic [6:0]  w_row_b;
  logic [9:0]  w_row_val;
  logic [15:0] w_row_shifted;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    w_mask_in = 4'b1111;
    if (SKIP_ZERO_ROWS) begin
      for (int k = 0; k < 4; k++) begin
        w_mask_in[k] = |x[2*k +: 2];
      end
    end
  end

  always_comb begin
    w_row_t = row_t_0;
    w_row_b = row_b_0;
    unique case (r_row_sel)
      2'd0: begin w_row_t = row_t_0; w_row_b = row_b_0; end
      2'd1: begin w_row_t = row_t_1; w_row_b = row_b_1; end
      2'd2: begin w_row_t = row_t_2; w_row_b = row_b_2; end
      2'd3: begin w_row_t = row_t_3; w_row_b = row_b_3; end
      default: ;
    endcase
  end

  // Row k carries weight 4^k; a 10-bit row shifted by at most 6 still fits in 16 bits.
  assign w_row_val     = {1'b0, w_row_t} + {2'b00, w_row_b, 1'b0};
  assign w_row_shifted = {6'd0, w_row_val} << {r_row_sel, 1'b0};
  assign w_mask_rem    = r_mask & ~(4'b0001 << r_row_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op_x    <= 8'd0;
      r_op_y    <= 8'd0;
      r_acc     <= 16'd0;
      r_mask    <= 4'd0;
      r_row_sel <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op_x <= x;
            r_op_y <= y;
            r_acc  <= 16'd0;
            r_mask <= w_mask_in;
            if (w_mask_in == 4'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_row_sel <= lowest_set(w_mask_in);
              r_state   <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          r_acc  <= r_acc + w_row_shifted;
          r_mask <= w_mask_rem;
          if (w_mask_rem != 4'd0) begin
            r_row_sel <= lowest_set(w_mask_rem);
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_ACC) || (r_state == ST_DONE);
  assign out_valid = (r_state == ST_DONE);
  assign p         = r_acc;
  assign op_x      = r_op_x;
  assign op_y      = r_op_y;
  assign row_sel   = r_row_sel;

endmodule

// File: tb/tb_approx_mul_8x8_seq_ctrl.sv
// Bench for approx_mul_8x8_seq_ctrl: two instances (row skipping on/off) fed by stubbed
// compressor rows, checked every cycle against a transaction-level product/latency model.
module tb_approx_mul_8x8_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_a [2];
  logic        out_ready_a[2];
  logic [7:0]  x_a        [2];
  logic [7:0]  y_a        [2];
  logic        in_ready_a [2];
  logic        busy_a     [2];
  logic        out_valid_a[2];
  logic [7:0]  opx_a      [2];
  logic [7:0]  opy_a      [2];
  logic [1:0]  rs_a       [2];
  logic [15:0] p_a        [2];
  logic [8:0]  st[4];
  logic [6:0]  sb[4];

  int n_checks = 0;
  int n_err    = 0;

  // index 0: all rows always visited; index 1: zero rows skipped
  approx_mul_8x8_seq_ctrl #(.SKIP_ZERO_ROWS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .x(x_a[0]), .y(y_a[0]), .op_x(opx_a[0]), .op_y(opy_a[0]),
    .row_b_0(sb[0]), .row_b_1(sb[1]), .row_b_2(sb[2]), .row_b_3(sb[3]),
    .row_t_0(st[0]), .row_t_1(st[1]), .row_t_2(st[2]), .row_t_3(st[3]),
    .row_sel(rs_a[0]), .busy(busy_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .p(p_a[0])
  );

  approx_mul_8x8_seq_ctrl #(.SKIP_ZERO_ROWS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .x(x_a[1]), .y(y_a[1]), .op_x(opx_a[1]), .op_y(opy_a[1]),
    .row_b_0(sb[0]), .row_b_1(sb[1]), .row_b_2(sb[2]), .row_b_3(sb[3]),
    .row_t_0(st[0]), .row_t_1(st[1]), .row_t_2(st[2]), .row_t_3(st[3]),
    .row_sel(rs_a[1]), .busy(busy_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .p(p_a[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Transaction model: at handshake compute the visited rows and the product; then the
  // operation spends one cycle per row and waits in the result phase until accepted.
  bit      m_busy[2];
  int      m_pos [2];
  int      m_n   [2];
  int      m_rows[2][4];
  int      m_prod[2];
  int      m_x   [2];
  int      m_y   [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_pos[d] = 0; m_n[d] = 0; m_prod[d] = 0; m_x[d] = 0; m_y[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0;
        m_x[d] = 0;
        m_y[d] = 0;
      end else if (!m_busy[d]) begin
        if (in_valid_a[d]) begin
          m_busy[d] = 1;
          m_pos[d]  = 0;
          m_n[d]    = 0;
          m_prod[d] = 0;
          m_x[d]    = int'(x_a[d]);
          m_y[d]    = int'(y_a[d]);
          for (int k = 0; k < 4; k++) begin
            if (d == 0 || x_a[d][2*k +: 2] != 2'b00) begin
              m_rows[d][m_n[d]] = k;
              m_n[d]++;
              m_prod[d] += (int'(st[k]) + 2 * int'(sb[k])) << (2 * k);
            end
          end
          m_prod[d] = m_prod[d] & 32'hFFFF;
        end
      end else if (m_pos[d] < m_n[d]) begin
        m_pos[d]++;
      end else if (out_ready_a[d]) begin
        m_busy[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("in_ready", d, 32'(in_ready_a[d]), 32'(!m_busy[d]));
      chk("busy", d, 32'(busy_a[d]), 32'(m_busy[d]));
      chk("out_valid", d, 32'(out_valid_a[d]), 32'(m_busy[d] && m_pos[d] == m_n[d]));
      if (m_busy[d]) begin
        chk("op_x", d, 32'(opx_a[d]), m_x[d]);
        chk("op_y", d, 32'(opy_a[d]), m_y[d]);
        if (m_pos[d] < m_n[d]) chk("row_sel", d, 32'(rs_a[d]), m_rows[d][m_pos[d]]);
        else                   chk("p", d, 32'(p_a[d]), m_prod[d]);
      end
    end
  end

  task automatic set_rows(input logic [8:0] t0, t1, t2, t3, input logic [6:0] b0, b1, b2, b3);
    st[0] = t0; st[1] = t1; st[2] = t2; st[3] = t3;
    sb[0] = b0; sb[1] = b1; sb[2] = b2; sb[3] = b3;
  endtask

  task automatic run_op(input int d, input logic [7:0] xv, input logic [7:0] yv,
                        input int hold, input bit keep, input int exp_n,
                        input logic [15:0] exp_p);
    int g;
    int lat;
    @(negedge clk);
    x_a[d] = xv;
    y_a[d] = yv;
    in_valid_a[d]  = 1'b1;
    out_ready_a[d] = (hold == 0);
    g = 0;
    while (in_ready_a[d] !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", d, 32'(g < 20), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid_a[d] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (out_valid_a[d] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", d, lat, exp_n);
    chk("product", d, 32'(p_a[d]), 32'(exp_p));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", d, 32'(out_valid_a[d]), 32'd1);
        chk("hold_p", d, 32'(p_a[d]), 32'(exp_p));
        chk("hold_in_ready", d, 32'(in_ready_a[d]), 32'd0);
      end
      out_ready_a[d] = 1'b1;
    end
    @(negedge clk);
    chk("back_idle", d, 32'(in_ready_a[d]), 32'd1);
    in_valid_a[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b1; x_a[d] = 8'h00; y_a[d] = 8'h00;
    end
    set_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 1, 32'(in_ready_a[1]), 32'd1);
    chk("rst_busy", 1, 32'(busy_a[1]), 32'd0);
    chk("rst_out_valid", 1, 32'(out_valid_a[1]), 32'd0);
    chk("rst_p", 1, 32'(p_a[1]), 32'd0);
    chk("rst_row_sel", 1, 32'(rs_a[1]), 32'd0);
    chk("rst_op_x", 1, 32'(opx_a[1]), 32'd0);

    // all four rows, each worth 1 at weight 4^k: 1+4+16+64
    set_rows(9'h001, 9'h001, 9'h001, 9'h001, 7'h0, 7'h0, 7'h0, 7'h0);
    run_op(1, 8'hFF, 8'h01, 0, 0, 4, 16'd85);

    // single row 1: (511 + 2*127) << 2
    set_rows(9'h000, 9'h1FF, 9'h000, 9'h000, 7'h0, 7'h7F, 7'h0, 7'h0);
    run_op(1, 8'h0C, 8'h5A, 0, 0, 1, 16'd3060);

    // empty mask goes straight to the result
    run_op(1, 8'h00, 8'hAB, 0, 0, 0, 16'd0);

    // rows 0 and 3 with distinct values: 12 + (48 << 6)
    set_rows(9'd10, 9'd20, 9'd30, 9'd40, 7'd1, 7'd2, 7'd3, 7'd4);
    run_op(1, 8'hC3, 8'h77, 0, 0, 2, 16'd3084);

    // no skipping: four cycles, only row 0 nonzero, 171 + 2*21
    set_rows(9'h0AB, 9'h000, 9'h000, 9'h000, 7'h15, 7'h0, 7'h0, 7'h0);
    run_op(0, 8'h01, 8'h02, 0, 0, 4, 16'd213);

    // consumer stall in the result phase
    set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    run_op(1, 8'hFF, 8'hFF, 5, 0, 4, 16'd65025);

    // in_valid held through the accepting edge must not start a new operation there
    set_rows(9'h010, 9'h000, 9'h000, 9'h000, 7'h0, 7'h0, 7'h0, 7'h0);
    run_op(1, 8'h03, 8'h11, 0, 1, 1, 16'd16);
    run_op(1, 8'h00, 8'h22, 0, 0, 0, 16'd0);

    // reset during the second accumulate cycle discards the partial sum
    set_rows(9'h001, 9'h001, 9'h001, 9'h001, 7'h0, 7'h0, 7'h0, 7'h0);
    @(negedge clk);
    x_a[1] = 8'hFF;
    in_valid_a[1] = 1'b1;
    @(posedge clk);
    #1 in_valid_a[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 1, 32'(in_ready_a[1]), 32'd1);
    chk("mid_rst_out_valid", 1, 32'(out_valid_a[1]), 32'd0);
    chk("mid_rst_busy", 1, 32'(busy_a[1]), 32'd0);
    chk("mid_rst_p", 1, 32'(p_a[1]), 32'd0);

    // row 2 only: (5 + 6) << 4
    set_rows(9'h000, 9'h000, 9'h005, 9'h000, 7'h0, 7'h0, 7'h03, 7'h0);
    run_op(1, 8'h30, 8'h09, 0, 0, 1, 16'd176);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
